// File: rtl/decomp_frame_ctrl.sv
// Frame sequencer for the decompression engine: feeds blocks, flushes the tail, drains the pipe.
// Optional macro DFC_BACKPRESSURE_EN adds a downstream m_ready that stalls block and flush issue.
module decomp_frame_ctrl #(
  parameter int FLUSH_BLOCKS = 1,
  parameter int ENG_LATENCY  = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] frame_blocks,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             eng_valid,
  output logic             eng_sel_zero,
  input  logic             eng_dout_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] out_count,
`ifdef DFC_BACKPRESSURE_EN
  input  logic             m_ready,
`endif
  output logic             err
);

  localparam int FW = (FLUSH_BLOCKS > 1) ? $clog2(FLUSH_BLOCKS) : 1;
  localparam int DW = (ENG_LATENCY > 1) ? $clog2(ENG_LATENCY) : 1;
  localparam logic [FW-1:0] FL_LAST = FW'((FLUSH_BLOCKS > 0) ? FLUSH_BLOCKS - 1 : 0);
  localparam logic [DW-1:0] DR_LAST = DW'((ENG_LATENCY > 0) ? ENG_LATENCY - 1 : 0);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] frame_q, frame_d;
  logic [CNT_W-1:0] blk_q, blk_d;
  logic [CNT_W-1:0] oc_q, oc_d;
  logic [FW-1:0]    fl_q, fl_d;
  logic [DW-1:0]    dr_q, dr_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic             mrdy;
  logic             hs;
  logic             fl_issue;
  logic [CNT_W-1:0] blk_inc;

`ifdef DFC_BACKPRESSURE_EN
  assign mrdy = m_ready;
`else
  assign mrdy = 1'b1;
`endif

  // Abort kills issue in the same cycle so nothing reaches the engine after it.
  assign s_ready      = (state_q == RUN) & mrdy & ~abort;
  assign hs           = s_valid & s_ready;
  assign fl_issue     = (state_q == FLUSH) & mrdy & ~abort;
  assign eng_valid    = hs | fl_issue;
  assign eng_sel_zero = (state_q == FLUSH);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign out_count    = oc_q;
  assign err          = err_q;
  assign blk_inc      = blk_q + 1'b1;

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    blk_d   = blk_q;
    oc_d    = oc_q;
    fl_d    = fl_q;
    dr_d    = dr_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (frame_blocks != '0) begin
            state_d = RUN;
            frame_d = frame_blocks;
            blk_d   = '0;
            oc_d    = '0;
            err_d   = 1'b0;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      RUN: begin
        if (hs) begin
          blk_d = blk_inc;
          if (blk_inc == frame_q) begin
            state_d = (FLUSH_BLOCKS != 0) ? FLUSH : DRAIN;
            fl_d    = '0;
            dr_d    = '0;
          end
        end
      end
      FLUSH: begin
        if (fl_issue) begin
          if (fl_q == FL_LAST) begin
            state_d = DRAIN;
            dr_d    = '0;
          end else begin
            fl_d    = fl_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (dr_q == DR_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          dr_d    = dr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Engine output outside a frame is a protocol error and is not counted.
    if (eng_dout_valid) begin
      if (state_q != IDLE) oc_d  = oc_q + 1'b1;
      else                 err_d = 1'b1;
    end

    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      blk_q   <= '0;
      oc_q    <= '0;
      fl_q    <= '0;
      dr_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      blk_q   <= blk_d;
      oc_q    <= oc_d;
      fl_q    <= fl_d;
      dr_q    <= dr_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_decomp_frame_ctrl.sv
// Scoreboard bench for decomp_frame_ctrl: stimulus queues expected issues/done, a monitor checks them.
module tb_decomp_frame_ctrl;
  localparam int FB  = 1;
  localparam int LAT = 4;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, s_valid;
  logic [CW-1:0] frame_blocks;
  logic          s_ready, eng_valid, eng_sel_zero, eng_dout_valid;
  logic          busy, done, err;
  logic [CW-1:0] out_count;
`ifdef DFC_BACKPRESSURE_EN
  logic          m_ready = 1'b1;
`endif

  decomp_frame_ctrl #(.FLUSH_BLOCKS(FB), .ENG_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .frame_blocks(frame_blocks), .s_valid(s_valid), .s_ready(s_ready),
    .eng_valid(eng_valid), .eng_sel_zero(eng_sel_zero),
    .eng_dout_valid(eng_dout_valid), .busy(busy), .done(done),
    .out_count(out_count),
`ifdef DFC_BACKPRESSURE_EN
    .m_ready(m_ready),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  // Engine model: 3-cycle pipe, first issue after power-up only primes history.
  bit [2:0] pipe   = '0;
  bit       primed = 1'b0;
  always @(posedge clk) begin
    pipe <= {pipe[1:0], eng_valid & primed};
    if (eng_valid) primed <= 1'b1;
  end
  assign eng_dout_valid = pipe[2];

  typedef struct {bit is_done; bit sel_zero; int cnt;} exp_t;
  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, last_zero = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int blocks, input int outs);
    exp_t e;
    for (int i = 0; i < blocks; i++) begin e = '{0, 0, 0}; q.push_back(e); end
    for (int i = 0; i < FB; i++)     begin e = '{0, 1, 0}; q.push_back(e); end
    e = '{1, 0, outs}; q.push_back(e);
  endtask

  task automatic start_frame(input int blocks);
    start = 1'b1; frame_blocks = CW'(blocks); s_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", int'(busy), 1);
  endtask

  task automatic wait_done(input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("done_seen", int'(seen), 1);
  endtask

  // Monitor: every issue and every done must match the head of the scoreboard.
  exp_t me;
  always @(negedge clk) begin
    if (rst_n) begin
      if (eng_valid) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_issue: sel_zero=%0d, nothing expected (t=%0t)", eng_sel_zero, $time);
        end else begin
          me = q.pop_front();
          chk("event_is_done", 0, int'(me.is_done));
          chk("issue_sel_zero", int'(eng_sel_zero), int'(me.sel_zero));
        end
        if (eng_sel_zero) last_zero = cyc;
      end
      if (done) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: out_count=%0d, nothing expected (t=%0t)", out_count, $time);
        end else begin
          me = q.pop_front();
          chk("event_is_done", 1, int'(me.is_done));
          chk("done_out_count", int'(out_count), me.cnt);
          chk("drain_len", cyc - last_zero, LAT + 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit busy_drop;
    bit seen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; frame_blocks = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_eng_valid", int'(eng_valid), 0);
    chk("rst_sel_zero", int'(eng_sel_zero), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out_count", int'(out_count), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First frame after reset: one output lost to engine priming.
    push_frame(3, 3);
    start_frame(3);
    wait_done(40);
    s_valid = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    chk("out_count_held", int'(out_count), 3);

    // Second frame, with a start while busy that must be ignored.
    push_frame(3, 4);
    start_frame(3);
    start = 1'b1; frame_blocks = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40);
    s_valid = 1'b0;
    chk("err_clean_frame", int'(err), 0);

    // Zero-length frame.
    @(posedge clk); #1;
    start = 1'b1; frame_blocks = '0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_frame_err", int'(err), 1);
    chk("zero_frame_busy", int'(busy), 0);

    // Abort and start together in IDLE: start ignored.
    start = 1'b1; abort = 1'b1; frame_blocks = 16'd3;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", int'(busy), 0);
    chk("abort_start_err", int'(err), 1);

    // Gapped input, 5 blocks.
    push_frame(5, 6);
    start = 1'b1; frame_blocks = 16'd5; s_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_clears_err", int'(err), 0);
    busy_drop = 1'b0; seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (!busy) busy_drop = 1'b1;
      s_valid = ~s_valid;
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    s_valid = 1'b0;
    chk("gap_done_seen", int'(seen), 1);
    chk("gap_busy_drop", int'(busy_drop), 0);

    // Abort during FLUSH.
    for (int i = 0; i < 2; i++) begin me = '{0, 0, 0}; q.push_back(me); end
    start_frame(2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("in_flush", int'(eng_sel_zero), 1);
    abort = 1'b1;
    #1;
    chk("abort_eng_valid_now", int'(eng_valid), 0);
    @(posedge clk); #1;
    abort = 1'b0; s_valid = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_eng_valid", int'(eng_valid), 0);
    repeat (6) @(posedge clk);
    #1;
    chk("late_dout_err", int'(err), 1);
    chk("late_dout_out_count", int'(out_count), 0);

    // Normal frame after abort.
    push_frame(1, 2);
    start_frame(1);
    wait_done(40);
    s_valid = 1'b0;

`ifdef DFC_BACKPRESSURE_EN
    push_frame(4, 5);
    start_frame(4);
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_s_ready", int'(s_ready), 0);
      chk("bp_eng_valid", int'(eng_valid), 0);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    wait_done(40);
    s_valid = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/decomp_frame_ctrl.md
DECOMP_FRAME_CTRL -- requirements
Module: decomp_frame_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_BLOCKS, default 1: zero-valued 8-sample blocks injected after the frame to push the 7-sample tail history out.
REQ-002 SHALL have parameter ENG_LATENCY, default 4: cycles from the last engine issue until its result is guaranteed out.
REQ-003 SHALL have parameter CNT_W, default 16: width of the block and output counters.
REQ-004 clk  in  1  clock; all state on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 start  in  1  one-cycle frame start request.
REQ-007 abort  in  1  abandon the current frame.
REQ-008 frame_blocks  in  CNT_W  input blocks in the frame; sampled on an accepted start.
REQ-009 s_valid  in  1  upstream block valid.
REQ-010 s_ready  out  1  controller accepts a block.
REQ-011 eng_valid  out  1  drives the engine din_valid.
REQ-012 eng_sel_zero  out  1  engine input mux selects all-zero samples.
REQ-013 eng_dout_valid  in  1  engine output-valid strobe.
REQ-014 busy  out  1  high in any state except IDLE.
REQ-015 done  out  1  one-cycle end-of-frame pulse.
REQ-016 out_count  out  CNT_W  engine outputs counted this frame.
REQ-017 err  out  1  sticky error flag, cleared by an accepted start.

Function
REQ-018 SHALL implement states IDLE, RUN, FLUSH, DRAIN.
REQ-019 IDLE: start=1 with frame_blocks!=0 -> RUN next cycle; latch frame_blocks; clear block count, out_count and err.
REQ-020 start=1 with frame_blocks==0 -> stay in IDLE, set err, no done.
REQ-021 start while busy SHALL be ignored with no state change.
REQ-022 RUN: s_ready=1; eng_valid = s_valid & s_ready (combinational, same cycle); eng_sel_zero=0; each handshake increments the block count.
REQ-023 RUN -> FLUSH on the handshake that makes block count equal the latched frame_blocks.
REQ-024 FLUSH: s_ready=0; eng_valid=1 and eng_sel_zero=1 for exactly FLUSH_BLOCKS consecutive cycles, then -> DRAIN.
REQ-025 FLUSH_BLOCKS=0 SHALL make the RUN exit go directly to DRAIN.
REQ-026 DRAIN: eng_valid=0; count ENG_LATENCY cycles, then -> IDLE with done=1 in the cycle IDLE is entered.
REQ-027 out_count SHALL increment on every eng_dout_valid while busy, and hold its value in IDLE until the next accepted start.
REQ-028 eng_dout_valid while in IDLE SHALL set err and SHALL not change out_count.
REQ-029 abort in any busy state -> IDLE next cycle; no done; s_ready and eng_valid low from that cycle; out_count held.
REQ-030 abort and start in the same cycle: abort wins; start is ignored.
REQ-031 Counter overflow: the block counter is CNT_W wide, so no wrap is possible within a legal frame.

Reset
REQ-032 Reset SHALL force state IDLE with all outputs 0: s_ready, eng_valid, eng_sel_zero, busy, done, out_count, err.
REQ-033 Reset asserted mid-frame SHALL drop the frame with no done.
REQ-034 The engine's own history is not cleared by this block; the first frame after reset yields one fewer output (engine priming).

Configuration
REQ-035 Macro DFC_BACKPRESSURE_EN adds input m_ready (1 bit, downstream ready).
REQ-036 With DFC_BACKPRESSURE_EN defined: s_ready = RUN & m_ready; FLUSH issue pauses (eng_valid=0, flush count held) while m_ready=0.
REQ-037 Without DFC_BACKPRESSURE_EN: no m_ready port; behaviour is identical to m_ready tied to 1.

Verification
REQ-038 Reset, then start with frame_blocks=3 and s_valid held high -> eng_valid high 3 cycles (sel_zero=0), then 1 cycle with sel_zero=1, DRAIN 4 cycles, done pulse; out_count=3 on the first frame after reset.
REQ-039 Second identical frame -> out_count=4.
REQ-040 start with frame_blocks=0 -> err=1, busy stays 0, no done.
REQ-041 frame_blocks=5, s_valid gapped 1-on/1-off -> exactly 5 RUN issues and done; busy high throughout.
REQ-042 abort during FLUSH -> IDLE next cycle, no done, eng_valid=0; a following start is accepted normally.
REQ-043 With DFC_BACKPRESSURE_EN: m_ready=0 for 3 cycles mid-RUN -> s_ready=0 and no issue; block count resumes correctly; total issues = frame_blocks + FLUSH_BLOCKS.
